// File: rtl/riscv_core_div_unit_if.sv
// Start/operand/result bundle between the mul/div controller and the
// iterative divider.
interface riscv_core_div_unit_if #(
  parameter int XLEN = 64
);
  logic            i_div_start;
  logic [XLEN-1:0] i_div_srcA;
  logic [XLEN-1:0] i_div_srcB;
  logic [1:0]      i_div_control;
  logic            i_div_isword;
  logic [XLEN-1:0] o_div_result;
  logic            o_div_dn;
  logic            o_div_busy;

  modport master (
    output i_div_start, i_div_srcA, i_div_srcB, i_div_control, i_div_isword,
    input  o_div_result, o_div_dn, o_div_busy
  );

  modport slave (
    input  i_div_start, i_div_srcA, i_div_srcB, i_div_control, i_div_isword,
    output o_div_result, o_div_dn, o_div_busy
  );
endinterface

// File: rtl/riscv_core_div_unit.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants;
// one quotient bit per cycle, fixed N+2 cycle latency.
module riscv_core_div_unit #(
  parameter int XLEN = 64
) (
  input  logic                  i_mul_div_ctrl_clk,
  input  logic                  i_mul_div_ctrl_rstn,
  riscv_core_div_unit_if.slave  div_if
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem_r, quo_r, dvsr_r, dvnd_r, result_r;
  logic              q_neg, r_neg, is_rem, is_word, div0, ovf;

  logic signed [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0]        a_mag, b_mag, min_val;
  logic                   signed_op, a_sgn, b_sgn, ovf_in, div0_in;
  logic [XLEN:0]          r_sh, trial;

  function automatic logic [XLEN-1:0] fix_result(
    input logic [XLEN-1:0] quo, rem, dvnd,
    input logic qn, rn, rem_sel, word, dz, ov
  );
    logic [XLEN-1:0] q, r, sel;
    q = qn ? -quo : quo;
    r = rn ? -rem : rem;
    if (dz) begin
      q = '1;
      r = dvnd;
    end else if (ov) begin
      q = dvnd;
      r = '0;
    end
    sel = rem_sel ? r : q;
    if (word) sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
    return sel;
  endfunction

  // Operand preparation: width select, extension, magnitudes, special cases
  always_comb begin
    signed_op = ~div_if.i_div_control[0];
    if (div_if.i_div_isword) begin
      a_ext   = signed_op ? {{(XLEN-32){div_if.i_div_srcA[31]}}, div_if.i_div_srcA[31:0]}
                          : {{(XLEN-32){1'b0}}, div_if.i_div_srcA[31:0]};
      b_ext   = signed_op ? {{(XLEN-32){div_if.i_div_srcB[31]}}, div_if.i_div_srcB[31:0]}
                          : {{(XLEN-32){1'b0}}, div_if.i_div_srcB[31:0]};
      min_val = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext   = div_if.i_div_srcA;
      b_ext   = div_if.i_div_srcB;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_sgn   = signed_op & a_ext[XLEN-1];
    b_sgn   = signed_op & b_ext[XLEN-1];
    // Negating the most-negative value wraps to itself, which read unsigned is 2^(w-1)
    a_mag   = a_sgn ? -a_ext : a_ext;
    b_mag   = b_sgn ? -b_ext : b_ext;
    div0_in = ($unsigned(b_ext) == '0);
    ovf_in  = signed_op & ($unsigned(a_ext) == min_val) & ($unsigned(b_ext) == '1);
  end

  // Restoring step: shift {R,Q} left, trial-subtract the divisor magnitude
  always_comb begin
    r_sh  = {rem_r, quo_r[XLEN-1]};
    trial = r_sh - {1'b0, dvsr_r};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (div_if.i_div_start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_mul_div_ctrl_clk or negedge i_mul_div_ctrl_rstn) begin
    if (!i_mul_div_ctrl_rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      dvnd_r   <= '0;
      result_r <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      is_rem   <= 1'b0;
      is_word  <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (div_if.i_div_start) begin
          cnt     <= div_if.i_div_isword ? CNT_W'(XLEN/2 - 1) : CNT_W'(XLEN - 1);
          rem_r   <= '0;
          // W dividends sit in the top half so 32 shifts bring every bit through
          quo_r   <= div_if.i_div_isword ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
          dvsr_r  <= b_mag;
          dvnd_r  <= a_ext;
          q_neg   <= a_sgn ^ b_sgn;
          r_neg   <= a_sgn;
          is_rem  <= div_if.i_div_control[1];
          is_word <= div_if.i_div_isword;
          div0    <= div0_in;
          ovf     <= ovf_in;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (!trial[XLEN]) begin
            rem_r <= trial[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], 1'b1};
          end else begin
            rem_r <= r_sh[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], 1'b0};
          end
        end
        FIX: result_r <= fix_result(quo_r, rem_r, dvnd_r, q_neg, r_neg, is_rem,
                                    is_word, div0, ovf);
        default: ;
      endcase
    end
  end

  assign div_if.o_div_result = result_r;
  assign div_if.o_div_dn     = (state == DONE);
  assign div_if.o_div_busy   = (state != IDLE);

endmodule

// File: tb/tb_riscv_core_div_unit.sv
// Scoreboard bench for riscv_core_div_unit: directed RISC-V corner cases plus
// randomized operations checked against an arithmetic reference model.
module tb_riscv_core_div_unit;
  localparam int XLEN = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_core_div_unit_if #(.XLEN(XLEN)) div_if ();

  riscv_core_div_unit #(.XLEN(XLEN)) dut (
    .i_mul_div_ctrl_clk  (clk),
    .i_mul_div_ctrl_rstn (rstn),
    .div_if              (div_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic
  function automatic logic [63:0] ref_div(input logic [63:0] a, b, input logic [1:0] ctl,
                                          input logic w);
    logic [63:0] ua, ub, q, r, res;
    longint      sa, sb;
    if (w) begin
      ua = ctl[0] ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
      ub = ctl[0] ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
    end else begin
      ua = a;
      ub = b;
    end
    if (ub == 64'd0) begin
      q = '1;
      r = ua;
    end else if (ctl[0]) begin
      q = ua / ub;
      r = ua % ub;
    end else if (ua == 64'h8000_0000_0000_0000 && ub == '1) begin
      q = ua;
      r = '0;
    end else begin
      sa = signed'(ua);
      sb = signed'(ub);
      q  = sa / sb;
      r  = sa % sb;
    end
    res = ctl[1] ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn && div_if.o_div_dn === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected no done", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result", div_if.o_div_result, e.res);
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("busy_in_done", 64'(div_if.o_div_busy), 64'd1);
      end
    end
  end

  task automatic start_op(input logic [63:0] a, b, input logic [1:0] ctl, input logic w,
                          input logic [63:0] expv, input bit accept, output int k);
    @(negedge clk);
    div_if.i_div_srcA    = a;
    div_if.i_div_srcB    = b;
    div_if.i_div_control = ctl;
    div_if.i_div_isword  = w;
    div_if.i_div_start   = 1'b1;
    @(negedge clk);
    div_if.i_div_start   = 1'b0;
    div_if.i_div_srcA    = {$urandom(), $urandom()};
    div_if.i_div_srcB    = {$urandom(), $urandom()};
    div_if.i_div_control = 2'($urandom_range(0, 3));
    div_if.i_div_isword  = 1'($urandom_range(0, 1));
    k = cyc;
    if (accept) sbq.push_back('{res: expv, done_cyc: k + (w ? 32 : 64) + 1});
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (div_if.o_div_dn === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in 200 cycles, expected a done pulse");
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_op(input logic [63:0] a, b, input logic [1:0] ctl, input logic w,
                        input logic [63:0] expv);
    int k;
    start_op(a, b, ctl, w, expv, 1'b1, k);
    wait_done();
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'h8000_0000_0000_0000;
      1:       v = '1;
      2:       v = '0;
      3:       v = 64'($urandom_range(1, 20));
      4:       v = 64'h0000_0000_8000_0000;
      5:       v = {32'($urandom()), 32'($urandom())} | 64'h8000_0000_0000_0000;
      default: v = {32'($urandom()), 32'($urandom())};
    endcase
    return v;
  endfunction

  initial begin : driver
    int          k;
    logic [63:0] a, b;
    logic [1:0]  ctl;
    logic        w;

    div_if.i_div_start   = 1'b0;
    div_if.i_div_srcA    = '0;
    div_if.i_div_srcB    = '0;
    div_if.i_div_control = '0;
    div_if.i_div_isword  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_result", div_if.o_div_result, 64'd0);
    chk("reset_dn", 64'(div_if.o_div_dn), 64'd0);
    chk("reset_busy", 64'(div_if.o_div_busy), 64'd0);
    rstn = 1'b1;

    // DIV 20 / -3 with busy and single-cycle done checks
    start_op(64'd20, -64'sd3, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, k);
    chk("busy_after_start", 64'(div_if.o_div_busy), 64'd1);
    wait_done();
    @(negedge clk);
    chk("dn_one_cycle", 64'(div_if.o_div_dn), 64'd0);
    chk("idle_after_done", 64'(div_if.o_div_busy), 64'd0);
    chk("result_held", div_if.o_div_result, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(64'd20, -64'sd3, 2'b10, 1'b0, 64'd2);
    run_op(-64'sd20, 64'd3, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 2'b11, 1'b0, 64'd5);
    run_op(64'h1_FFFF_FFFF, 64'd2, 2'b01, 1'b1, 64'h0000_0000_7FFF_FFFF);
    run_op(64'hFFFF_FFFF, 64'd1, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'd12345, 64'd0, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h1234, 64'd0, 2'b10, 1'b0, 64'h1234);
    run_op(64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, 64'h8000_0000_0000_0000);
    run_op(64'h8000_0000, '1, 2'b10, 1'b1, 64'd0);
    run_op(-64'sd7, 64'd0, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h8000_0000, '1, 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000);

    // Start while busy is ignored
    start_op(64'd1000, 64'd7, 2'b00, 1'b0, 64'd142, 1'b1, k);
    wait_cyc(k + 9);
    start_op(64'd999, 64'd3, 2'b01, 1'b1, 64'd0, 1'b0, k);
    wait_done();

    // Start during DONE is ignored; next start from IDLE accepted
    start_op(64'd50, 64'd5, 2'b01, 1'b0, 64'd10, 1'b1, k);
    wait_cyc(k + 64);
    start_op(64'd77, 64'd7, 2'b01, 1'b0, 64'd0, 1'b0, k);
    chk("done_cycle_start_ignored", 64'(div_if.o_div_busy), 64'd0);
    run_op(-64'sd7, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);

    // Asynchronous reset in the middle of CALC
    start_op(64'd123456, 64'd11, 2'b00, 1'b0, 64'd11223, 1'b1, k);
    wait_cyc(k + 30);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_busy", 64'(div_if.o_div_busy), 64'd0);
    chk("async_rst_dn", 64'(div_if.o_div_dn), 64'd0);
    chk("async_rst_result", div_if.o_div_result, 64'd0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    run_op(64'd100, 64'd7, 2'b01, 1'b0, 64'd14);

    for (int i = 0; i < 40; i++) begin
      a   = pick();
      b   = pick();
      ctl = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      run_op(a, b, ctl, w, ref_div(a, b, ctl, w));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
